// File: rtl/cpu_buttons.sv
// Avalon-MM push-button port: per-pin 2-flop synchronizer and debouncer,
// press-edge capture register, interrupt mask and level interrupt.
module cpu_buttons #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1_r;
  logic [WIDTH-1:0]         sync2_r;
  logic [WIDTH-1:0]         stable_r;
  logic [WIDTH-1:0][CW-1:0] cnt_r;
  logic [WIDTH-1:0]         irqmask_r;
  logic [WIDTH-1:0]         edgecap_r;
  logic [31:0]              readdata_r;

  logic [WIDTH-1:0][CW-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]         stable_nxt_s;
  logic [WIDTH-1:0]         press_s;
  logic [WIDTH-1:0]         wdata_s;
  logic [WIDTH-1:0]         clr_s;
  logic [WIDTH-1:0]         irqmask_nxt_s;
  logic [WIDTH-1:0]         edgecap_nxt_s;
  logic [31:0]              rdata_nxt_s;
  logic                     wr_s;
  logic                     rd_s;
  logic                     unused_wdata_s;

  assign wr_s           = chipselect & ~write_n;
  assign rd_s           = chipselect & write_n;
  assign wdata_s        = writedata[WIDTH-1:0];
  assign unused_wdata_s = ^writedata;

  // Debounce: a pin must differ from its stable value for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    cnt_nxt_s    = '0;
    stable_nxt_s = stable_r;
    press_s      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == TERM) begin
        cnt_nxt_s[i]    = '0;
        stable_nxt_s[i] = sync2_r[i];
        press_s[i]      = ~sync2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Register-map decode; a press arriving with a clear of the same bit wins
  always_comb begin
    irqmask_nxt_s = irqmask_r;
    clr_s         = '0;
    rdata_nxt_s   = 32'h0000_0000;
    if (wr_s && (address == 2'd2)) begin
      irqmask_nxt_s = wdata_s;
    end else begin
      irqmask_nxt_s = irqmask_r;
    end
    if (wr_s && (address == 2'd3)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
    if (rd_s) begin
      case (address)
        2'd0:    rdata_nxt_s = 32'(stable_r);
        2'd1:    rdata_nxt_s = 32'h0000_0000;
        2'd2:    rdata_nxt_s = 32'(irqmask_r);
        2'd3:    rdata_nxt_s = 32'(edgecap_r);
        default: rdata_nxt_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
    edgecap_nxt_s = (edgecap_r & ~clr_s) | press_s;
  end

  // Synchronizer, debounce state and bus registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r    <= '1;
      sync2_r    <= '1;
      stable_r   <= '1;
      cnt_r      <= '0;
      irqmask_r  <= '0;
      edgecap_r  <= '0;
      readdata_r <= 32'h0000_0000;
    end else begin
      sync1_r    <= in_port;
      sync2_r    <= sync1_r;
      stable_r   <= stable_nxt_s;
      cnt_r      <= cnt_nxt_s;
      irqmask_r  <= irqmask_nxt_s;
      edgecap_r  <= edgecap_nxt_s;
      readdata_r <= rdata_nxt_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_cpu_buttons.sv
// Bench for cpu_buttons: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a window-based reference model.
module tb_cpu_buttons;

  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  logic [W-1:0] pins;

  always #5 clk = ~clk;

  cpu_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // Reference model: pins reach the debouncer two edges late; a pin's stable
  // value flips once the last DC samples since the previous flip all differ.
  logic [W-1:0] m_s1, m_s2, m_stable, m_mask, m_edge;
  logic [31:0]  m_rd;
  logic         m_hist [W][DC];
  int           m_fill [W];

  task automatic model_step();
    logic [W-1:0] nst, press, clr;
    logic all_diff;
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_mask = '0; m_edge = '0; m_rd = 32'h0;
      for (int b = 0; b < W; b++) begin
        m_fill[b] = 0;
        for (int k = 0; k < DC; k++) m_hist[b][k] = 1'b0;
      end
    end else begin
      nst   = m_stable;
      press = '0;
      for (int b = 0; b < W; b++) begin
        for (int k = DC - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        if (m_fill[b] < DC) m_fill[b]++;
        all_diff = (m_fill[b] == DC);
        for (int k = 0; k < DC; k++) if (m_hist[b][k] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          nst[b]    = ~m_stable[b];
          m_fill[b] = 0;
          if (nst[b] == 1'b0) press[b] = 1'b1;
        end
      end
      if (chipselect && write_n) begin
        case (address)
          2'd0:    m_rd = {28'h0, m_stable};
          2'd2:    m_rd = {28'h0, m_mask};
          2'd3:    m_rd = {28'h0, m_edge};
          default: m_rd = 32'h0;
        endcase
      end else begin
        m_rd = 32'h0;
      end
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_edge   = (m_edge & ~clr) | press;
      m_s2     = m_s1;
      m_s1     = in_port;
      m_stable = nst;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (readdata !== m_rd) begin
        n_errors++;
        $display("FAIL model_readdata t=%0t got 0x%08h expected 0x%08h", $time, readdata, m_rd);
      end
      n_checks++;
      if (irq !== |(m_edge & m_mask)) begin
        n_errors++;
        $display("FAIL model_irq t=%0t got %0b expected %0b", $time, irq, |(m_edge & m_mask));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, model follows the edge, return at next negedge
  task automatic tick(input logic rn, input logic cs, input logic wn,
                      input logic [1:0] a, input logic [31:0] wd, input logic [W-1:0] p);
    reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, pins);
  endtask

  task automatic rd(input logic [1:0] a);
    tick(1'b1, 1'b1, 1'b1, a, 32'h0, pins);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, 1'b1, 1'b0, a, d, pins);
  endtask

  initial begin
    logic [31:0] rv [12];
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'h0; pins = '1; in_port = '1;
    @(negedge clk);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, pins);
    chk_en = 1'b1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    rd(2'd0); chk("rst_read_data", readdata, 32'h0000_000F);
    rd(2'd2); chk("rst_read_mask", readdata, 32'h0);
    rd(2'd3); chk("rst_read_edge", readdata, 32'h0);
    idle();   chk("idle_read_zero", readdata, 32'h0);

    // Press bit 1: capture appears exactly on the 6th edge
    pins = 4'hD;
    for (int k = 1; k <= 8; k++) begin rd(2'd3); rv[k] = readdata; end
    chk("press_edge_c6", rv[6], 32'h0);
    chk("press_edge_c7", rv[7], 32'h2);
    rd(2'd0); chk("press_data", readdata, 32'h0000_000D);
    chk("press_irq_masked", {31'h0, irq}, 32'h0);

    pins = 4'hF; repeat (8) idle();
    rd(2'd3); chk("release_no_edge", readdata, 32'h2);
    wr(2'd3, 32'h0); rd(2'd3); chk("clr_zero_keeps", readdata, 32'h2);
    wr(2'd1, 32'hFFFF_FFFF); rd(2'd1); chk("addr1_reads_zero", readdata, 32'h0);
    wr(2'd2, 32'hFFFF_FFF2); chk("mask_late_irq", {31'h0, irq}, 32'h1);
    rd(2'd2); chk("mask_upper_ignored", readdata, 32'h2);
    wr(2'd3, 32'h2); chk("clear_drops_irq", {31'h0, irq}, 32'h0);
    pins = 4'hD; repeat (5) idle();
    chk("irq_before_accept", {31'h0, irq}, 32'h0);
    idle(); chk("irq_on_accept", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'hFFFF_0002); chk("clear_upper_ignored", {31'h0, irq}, 32'h0);
    pins = 4'hF; repeat (8) idle();

    // Bounce bit 0: low 3, high 1, then held low
    for (int k = 1; k <= 11; k++) begin
      pins = (k == 4) ? 4'hF : 4'hE;
      rd(2'd0); rv[k] = readdata;
    end
    chk("bounce_c9", rv[9], 32'hF);
    chk("bounce_c10", rv[10], 32'hF);
    chk("bounce_c11", rv[11], 32'hE);
    rd(2'd3); chk("bounce_edge", readdata, 32'h1);
    wr(2'd3, 32'h1);
    pins = 4'hF; repeat (8) idle();

    // Clear and press of bit 2 on the same edge: set wins
    pins = 4'hB; repeat (5) idle();
    wr(2'd3, 32'h4);
    rd(2'd3); chk("set_wins", readdata, 32'h4);
    wr(2'd3, 32'h4);
    pins = 4'hF; repeat (8) idle();

    // Reset mid-debounce of bit 3, pin still held low afterwards
    pins = 4'h7; repeat (4) idle();
    tick(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, pins);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      rd((k == 1) ? 2'd0 : 2'd3); rv[k] = readdata;
    end
    chk("rst_mid_stable", rv[1], 32'hF);
    chk("rst_mid_edge_c2", rv[2], 32'h0);
    chk("rst_mid_edge_c6", rv[6], 32'h0);
    chk("rst_mid_edge_c7", rv[7], 32'h8);

    // Randomized traffic with bouncing pins and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) pins[$urandom_range(0, W - 1)] ^= 1'b1;
      tick(($urandom_range(0, 399) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom(), pins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_buttons.md
CPU_BUTTONS -- requirements
Module: cpu_buttons

Interface
REQ-001 Parameter WIDTH, default 4: number of push-button input pins.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles needed to accept a pin change; legal range 2 to 2^20.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe; read when high with chipselect.
REQ-008 writedata  input  32  write data.
REQ-009 in_port  input  WIDTH  asynchronous button pins, active-low (0 = pressed).
REQ-010 readdata  output  32  registered read data.
REQ-011 irq  output  1  level interrupt request to CPU.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL keep a debounced "stable" value and a cycle counter wide enough for DEBOUNCE_CYCLES-1.
REQ-014 Synchronized value equal to stable: counter SHALL be 0 next cycle.
REQ-015 Synchronized value differs and counter < DEBOUNCE_CYCLES-1: counter SHALL increment.
REQ-016 Synchronized value differs and counter = DEBOUNCE_CYCLES-1: stable SHALL take the synchronized value and counter SHALL return to 0.
REQ-017 Any glitch back to the stable value before terminal count SHALL restart counting from 0; no partial credit is kept.
REQ-018 Net latency, pin change to stable update, SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean change.
REQ-019 A stable 1->0 transition (press) SHALL set the matching edgecapture bit on the same clock edge as the stable update; release edges SHALL NOT set it.
REQ-020 Register map, write = chipselect & ~write_n, data in bits [WIDTH-1:0], upper bits ignored on write and read as 0.
REQ-021 Address 0 (data): read returns stable; writes ignored.
REQ-022 Address 1: reads 0; writes ignored.
REQ-023 Address 2 (irqmask): read/write; bit=1 enables interrupt for that pin.
REQ-024 Address 3 (edgecapture): read returns captured bits; writing 1 to a bit clears it, writing 0 leaves it.
REQ-025 Clear write and new press on the same bit in the same cycle: bit SHALL end set (set wins).
REQ-026 readdata SHALL be registered: on each edge with chipselect & write_n it loads the addressed value, otherwise it loads 0; read latency 1 cycle.
REQ-027 irq SHALL equal OR of (edgecapture & irqmask), driven combinationally from registers; it stays asserted until cleared or masked.
REQ-028 Writing a mask bit to 1 while its edgecapture bit is already set SHALL assert irq in the following cycle.

Reset
REQ-029 While reset_n = 0 at a clk edge: synchronizer flops and stable = all ones, counters = 0, irqmask = 0, edgecapture = 0, readdata = 0; irq therefore 0.
REQ-030 Reset asserted mid-debounce SHALL discard the count; no edge is captured for that change.
REQ-031 A pin held low through reset release SHALL be debounced normally and capture one press DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 4)
REQ-032 Reset, then read addr 0, 2, 3 -> readdata 0x0000000F, 0x0, 0x0 one cycle after each read; irq 0.
REQ-033 Drive in_port[1] low and hold -> addr 0 reads 0xD and edgecapture bit 1 set exactly 6 cycles after the change; irq stays 0 (mask 0).
REQ-034 Write 0x2 to addr 2, then press bit 1 -> irq rises with edgecapture; write 0x2 to addr 3 -> irq 0 next cycle; write 0x0 to addr 3 earlier leaves it set.
REQ-035 Bounce in_port[0] low 3 cycles, high 1, low 3 -> no stable change; then hold low -> change accepted 4 cycles after the last synchronized bounce.
REQ-036 Clear-write to addr 3 bit 2 on the same edge bit 2 press is accepted -> edgecapture bit 2 reads 1.
REQ-037 Assert reset_n = 0 at counter = 2 during a press -> after release, counters 0, stable 0xF, edgecapture 0; press still held captures after 6 cycles.
